// File: rtl/qkd_pkg.sv
// qkd_pkg: state encoding and default geometry shared by the QKD sifting blocks
package qkd_pkg;
    localparam int ADDR_W_DEF = 10;
    localparam int W_DEF      = 8;
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_SEND    = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;
    typedef enum logic [2:0] {
        IDLE    = S_IDLE,
        FETCH   = S_FETCH,
        CAPTURE = S_CAPTURE,
        SEND    = S_SEND,
        DONE    = S_DONE
    } state_t;
endpackage

// File: rtl/qkd_bit_packer.sv
// qkd_bit_packer: LSB-first packing of paired Alice/Bob key bits into W-bit words
module qkd_bit_packer #(
    parameter int W  = 8,
    parameter int BW = $clog2(W) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          load,
    input  logic          a,
    input  logic          b,
    output logic [W-1:0]  word_a,
    output logic [W-1:0]  word_b,
    output logic [BW-1:0] bitcnt,
    output logic          full
);
    // The next load completes the word when one slot is left
    assign full = bitcnt == BW'(W - 1);

    // Clear wins over load; each load drops the bit pair into slot bitcnt
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_a <= '0;
            word_b <= '0;
            bitcnt <= '0;
        end else if (clear) begin
            word_a <= '0;
            word_b <= '0;
            bitcnt <= '0;
        end else if (load) begin
            word_a[bitcnt[BW-2:0]] <= a;
            word_b[bitcnt[BW-2:0]] <= b;
            bitcnt                 <= bitcnt + 1'b1;
        end
    end
endmodule

// File: rtl/qkd_sifted_key_reader.sv
// qkd_sifted_key_reader: streams sifted key bits from the key BRAMs as packed words and counts a/b mismatches
module qkd_sifted_key_reader
    import qkd_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int W      = W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_W:0]        key_len,
    output logic                   rd_en,
    output logic [ADDR_W-1:0]      rd_addr,
    input  logic                   rd_data_a,
    input  logic                   rd_data_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [W-1:0]           out_word_a,
    output logic [W-1:0]           out_word_b,
    output logic [$clog2(W):0]     out_nbits,
    output logic                   out_last,
    output logic [ADDR_W:0]        err_count,
    output logic                   busy,
    output logic                   done
);
    localparam int BW = $clog2(W) + 1;
    localparam logic [ADDR_W:0] DEPTH = (ADDR_W + 1)'(1) << ADDR_W;

    state_t          state;
    logic [ADDR_W:0] idx, len, idx_n, len_n;
    logic            accept, full;

    assign accept = start && (state == IDLE || state == DONE);
    assign idx_n  = idx + 1'b1;
    assign len_n  = key_len > DEPTH ? DEPTH : key_len;
    assign busy   = state != IDLE && state != DONE;
    assign done   = state == DONE;

    qkd_bit_packer #(.W(W), .BW(BW)) u_packer (
        .clk    (clk),
        .rst    (rst),
        .clear  (accept || (state == SEND && out_ready)),
        .load   (state == CAPTURE),
        .a      (rd_data_a),
        .b      (rd_data_b),
        .word_a (out_word_a),
        .word_b (out_word_b),
        .bitcnt (out_nbits),
        .full   (full)
    );

    // Readout sequencer: one FETCH/CAPTURE pair per bit, SEND once a word is full or the key ends
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            len       <= '0;
            err_count <= '0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        len       <= len_n;
                        idx       <= '0;
                        err_count <= '0;
                        if (len_n == '0) begin
                            state <= DONE;
                        end else begin
                            state   <= FETCH;
                            rd_en   <= 1'b1;
                            rd_addr <= '0;
                        end
                    end
                end
                FETCH: begin
                    rd_en <= 1'b0;
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    err_count <= err_count + {{ADDR_W{1'b0}}, rd_data_a ^ rd_data_b};
                    idx       <= idx_n;
                    if (full || idx_n == len) begin
                        state     <= SEND;
                        out_valid <= 1'b1;
                        out_last  <= idx_n == len;
                    end else begin
                        state   <= FETCH;
                        rd_en   <= 1'b1;
                        rd_addr <= idx_n[ADDR_W-1:0];
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (out_last) begin
                            state <= DONE;
                        end else begin
                            state   <= FETCH;
                            rd_en   <= 1'b1;
                            rd_addr <= idx[ADDR_W-1:0];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/qkd_sifted_key_reader.md
Name: qkd_sifted_key_reader

Overview:
- Read-side counterpart of the sifting FSM. After sifting finishes, this block reads the sifted Alice/Bob key bits back out of the 1-bit-wide key BRAMs.
- It packs the bits into W-bit words and streams them over a valid/ready interface to downstream post-processing (error estimation / reconciliation).
- It also counts Alice/Bob bit mismatches seen during readout, as a cross-check of the sifting QBER.

Parameters:
- ADDR_W, 10, BRAM address width; memory depth is 2**ADDR_W.
- W, 8, output word width in key bits; legal range 2..16.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle request to begin readout; sampled only in IDLE or DONE
- key_len  in  ADDR_W+1  number of sifted bits to read, latched on accepted start
- rd_en  out  1  BRAM read enable
- rd_addr  out  ADDR_W  BRAM read address
- rd_data_a  in  1  Alice key bit; valid exactly 1 cycle after rd_en
- rd_data_b  in  1  Bob key bit; same timing as rd_data_a
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accept
- out_word_a  out  W  packed Alice bits
- out_word_b  out  W  packed Bob bits
- out_nbits  out  $clog2(W)+1  number of valid bits in the current word (1..W)
- out_last  out  1  current word is the final word of the key
- err_count  out  ADDR_W+1  running count of bit positions where a != b
- busy  out  1  high in any state other than IDLE and DONE
- done  out  1  high in DONE; cleared when a new start is accepted

Behaviour:
- Reset (asynchronous): state=IDLE; all outputs 0. This includes rd_en, rd_addr, out_*, err_count, busy and done. Internal idx, bitcnt, len and the shift registers are also cleared. A reset mid-readout aborts immediately; no partial word is emitted.
- States: IDLE, FETCH, CAPTURE, SEND, DONE.
- IDLE/DONE on start:
  - len := min(key_len, 2**ADDR_W); idx := 0; bitcnt := 0; err_count := 0; done := 0; word registers := 0.
  - If len==0: go to DONE, done=1 the next cycle, no words emitted.
  - Otherwise go to FETCH.
- start in FETCH, CAPTURE or SEND is ignored.
- FETCH: rd_en=1, rd_addr=idx (registered, asserted for exactly this one cycle); go to CAPTURE.
- CAPTURE:
  - rd_data valid. Write a into word_a[bitcnt] and b into word_b[bitcnt]; the first bit read goes to bit 0 (LSB-first).
  - If a!=b, err_count += 1.
  - idx += 1; bitcnt += 1.
  - If bitcnt+1==W or idx+1==len, go to SEND; otherwise go to FETCH.
  - rd_en=0 in this state.
- SEND:
  - out_valid=1. out_word_a/b, out_nbits=bitcnt, out_last=(idx==len) are all held stable while out_valid && !out_ready.
  - On out_valid && out_ready: clear the word registers and bitcnt.
    - If out_last, go to DONE.
    - Otherwise go to FETCH.
  - out_valid deasserts the cycle after the handshake.
- Partial final word: unused upper bits are 0; out_nbits = len mod W (W if the remainder is 0).
- DONE: done=1, busy=0, out_valid=0. err_count holds its final value until the next accepted start.
- Timing:
  - Per bit: 2 cycles (FETCH + CAPTURE).
  - Full word with immediate ready: 2*W + 1 cycles.
  - From start to first out_valid: 2*W + 1 cycles for len≥W.
- Widths: idx and len are ADDR_W+1 bits, so len = 2**ADDR_W (1024) is representable. rd_addr = idx[ADDR_W-1:0]. err_count ≤ len, so it never wraps.
- No out_valid may be asserted without a preceding read; rd_en is never asserted in SEND, IDLE or DONE.

Decomposition:
- Shared package qkd_pkg holds the state encoding (IDLE/FETCH/CAPTURE/SEND/DONE as a 3-bit localparam set) and the default ADDR_W and W constants shared with the sifting FSM.
- One natural sub-module: qkd_bit_packer. It holds the W-bit shift/index register pair and bitcnt, with clear, load_bit(a, b) and full outputs. The FSM stays in the top module.

Test Plan:
- Memory preloaded a=b=10110011 01 (LSB first), key_len=10, W=8, out_ready=1 → two words.
  - Word 1: word_a=8'b11001101, nbits=8, last=0.
  - Word 2: word_a=8'b00000010, nbits=2, last=1.
  - Final state: err_count=0, done=1.
- Same data with b flipped at indices 3 and 9 → err_count=2 at done; out_word_b differs from out_word_a in exactly those bit positions.
- out_ready held 0 for 5 cycles during word 1 → out_valid stays 1 and words are unchanged; rd_en stays 0 throughout the stall.
- key_len=0 → done=1 within 2 cycles; no out_valid, no rd_en.
- key_len=1500 with ADDR_W=10 → len clamped to 1024; 128 words emitted; rd_addr reaches 1023 and never wraps; final out_nbits=8 with last=1.
- rst asserted mid-word (after 4 captures) → all outputs 0 immediately. A subsequent start with key_len=8 produces exactly one correct word and err_count counts only the new run.
